// File: rtl/rv32i_pkg.sv
// Shared rv32i types: ALU operation encoding and the decode-to-execute bundle layout.
package rv32i_pkg;

  localparam int DPW_DEF = 32;
  localparam int ADW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8
  } alu_op_t;

  // Default-width layout; id_ex_pipe rebuilds the same layout at its own DPW/ADW.
  typedef struct packed {
    logic                 resultsrc;
    logic                 memwrite;
    logic                 alusrc;
    logic                 regwrite;
    alu_op_t              alu_ctrl;
    logic [DPW_DEF-1:0]   rd1;
    logic [DPW_DEF-1:0]   rd2;
    logic [DPW_DEF-1:0]   immext;
    logic [DPW_DEF-1:0]   pc;
    logic [ADW_DEF-1:0]   rs1;
    logic [ADW_DEF-1:0]   rs2;
    logic [ADW_DEF-1:0]   rd;
  } id_ex_bundle_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with an optional second (skid) entry and flush.
// Handshake: a transfer happens on a side in any cycle where its valid and ready are both 1.
module pipe_skid_buf #(
  parameter type T    = logic,
  parameter int  SKID = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic in_valid_i,
  input  logic in_block_i,
  input  T     in_data_i,
  output logic in_ready_o,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o,
  output logic young_valid_o,
  output T     young_data_o
);

  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  T     main_q, main_d, skid_q, skid_d;
  logic out_fire, in_fire, space;

  always_comb begin
    out_fire = main_v_q & out_ready_i;
    if (SKID != 0) space = !skid_v_q;
    else           space = !main_v_q | out_ready_i;
    in_ready_o = !rst_i & !flush_i & !in_block_i & space;
    in_fire    = in_valid_i & in_ready_o;

    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_fire) begin
      // Main slot frees up: the older skid entry takes precedence over new input.
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = in_fire;
        if (in_fire) skid_d = in_data_i;
      end else begin
        main_v_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_v_d = 1'b1;
      skid_d   = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign out_valid_o   = main_v_q;
  assign out_data_o    = main_q;
  assign young_valid_o = main_v_q | skid_v_q;
  assign young_data_o  = skid_v_q ? skid_q : main_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: valid/ready handshake, optional skid entry, flush,
// load-use hazard stall with bubble insertion and a saturating stall counter.
module id_ex_pipe
  import rv32i_pkg::*;
#(
  parameter int DPW  = 32,
  parameter int ADW  = 5,
  parameter int SKID = 1,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            resultsrcD,
  input  logic            memwriteD,
  input  logic            alusrcD,
  input  logic            regwriteD,
  input  alu_op_t         alu_ctrlD,
  input  logic [DPW-1:0]  rd1D,
  input  logic [DPW-1:0]  rd2D,
  input  logic [DPW-1:0]  immextD,
  input  logic [DPW-1:0]  pcD,
  input  logic [ADW-1:0]  Rs1D,
  input  logic [ADW-1:0]  Rs2D,
  input  logic [ADW-1:0]  RdD,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            resultsrcE,
  output logic            memwriteE,
  output logic            alusrcE,
  output logic            regwriteE,
  output alu_op_t         alu_ctrlE,
  output logic [DPW-1:0]  srcA,
  output logic [DPW-1:0]  Rd2E,
  output logic [DPW-1:0]  immextE,
  output logic [DPW-1:0]  pcE,
  output logic [ADW-1:0]  Rs1E,
  output logic [ADW-1:0]  Rs2E,
  output logic [ADW-1:0]  RdE,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic           resultsrc;
    logic           memwrite;
    logic           alusrc;
    logic           regwrite;
    alu_op_t        alu_ctrl;
    logic [DPW-1:0] rd1;
    logic [DPW-1:0] rd2;
    logic [DPW-1:0] immext;
    logic [DPW-1:0] pc;
    logic [ADW-1:0] rs1;
    logic [ADW-1:0] rs2;
    logic [ADW-1:0] rd;
  } bundle_t;

  bundle_t         d_bus, e_bus, y_bus;
  logic            y_valid, hazard, buf_valid;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    d_bus = '{resultsrc: resultsrcD, memwrite: memwriteD, alusrc: alusrcD,
              regwrite: regwriteD, alu_ctrl: alu_ctrlD, rd1: rd1D, rd2: rd2D,
              immext: immextD, pc: pcD, rs1: Rs1D, rs2: Rs2D, rd: RdD};
  end

  // Only the youngest held entry can still be a load the incoming bundle depends on.
  always_comb begin
    hazard = in_valid & y_valid & y_bus.resultsrc & y_bus.regwrite &
             (y_bus.rd != '0) & ((y_bus.rd == Rs1D) | (y_bus.rd == Rs2D));
  end

  pipe_skid_buf #(
    .T    (bundle_t),
    .SKID (SKID)
  ) u_buf (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_block_i    (hazard),
    .in_data_i     (d_bus),
    .in_ready_o    (in_ready),
    .out_valid_o   (buf_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (e_bus),
    .young_valid_o (y_valid),
    .young_data_o  (y_bus)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  // Side-effecting controls are forced low on bubbles so stale contents never commit.
  assign out_valid  = buf_valid;
  assign memwriteE  = e_bus.memwrite & buf_valid;
  assign regwriteE  = e_bus.regwrite & buf_valid;
  assign resultsrcE = e_bus.resultsrc;
  assign alusrcE    = e_bus.alusrc;
  assign alu_ctrlE  = e_bus.alu_ctrl;
  assign srcA       = e_bus.rd1;
  assign Rd2E       = e_bus.rd2;
  assign immextE    = e_bus.immext;
  assign pcE        = e_bus.pc;
  assign Rs1E       = e_bus.rs1;
  assign Rs2E       = e_bus.rs2;
  assign RdE        = e_bus.rd;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: table-driven load-use vectors, directed multi-cycle sequences,
// and a scoreboard tracking every accepted bundle through to the execute side.
module tb_id_ex_pipe;
  import rv32i_pkg::*;

  localparam int PW = 151;

  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic resultsrcD, memwriteD, alusrcD, regwriteD;
  alu_op_t alu_ctrlD;
  logic [31:0] rd1D, rd2D, immextD, pcD;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic in_ready, out_valid, resultsrcE, memwriteE, alusrcE, regwriteE;
  alu_op_t alu_ctrlE;
  logic [31:0] srcA, Rd2E, immextE, pcE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [3:0]  stall_cnt;

  logic in_ready0, out_valid0, resultsrcE0, memwriteE0, alusrcE0, regwriteE0;
  alu_op_t alu_ctrlE0;
  logic [31:0] srcA0, Rd2E0, immextE0, pcE0;
  logic [4:0]  Rs1E0, Rs2E0, RdE0;
  logic [15:0] stall_cnt0;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] d_pack, e_pack, exp_v;

  always #5 clk = ~clk;

  id_ex_pipe #(.DPW(32), .ADW(5), .SKID(1), .CNTW(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .resultsrcD(resultsrcD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regwriteD(regwriteD),
    .alu_ctrlD(alu_ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immextD(immextD), .pcD(pcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .out_valid(out_valid), .out_ready(out_ready),
    .resultsrcE(resultsrcE), .memwriteE(memwriteE), .alusrcE(alusrcE), .regwriteE(regwriteE),
    .alu_ctrlE(alu_ctrlE), .srcA(srcA), .Rd2E(Rd2E), .immextE(immextE), .pcE(pcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .stall_cnt(stall_cnt)
  );

  id_ex_pipe #(.DPW(32), .ADW(5), .SKID(0), .CNTW(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .flush(flush),
    .resultsrcD(resultsrcD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regwriteD(regwriteD),
    .alu_ctrlD(alu_ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immextD(immextD), .pcD(pcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .out_valid(out_valid0), .out_ready(out_ready),
    .resultsrcE(resultsrcE0), .memwriteE(memwriteE0), .alusrcE(alusrcE0), .regwriteE(regwriteE0),
    .alu_ctrlE(alu_ctrlE0), .srcA(srcA0), .Rd2E(Rd2E0), .immextE(immextE0), .pcE(pcE0),
    .Rs1E(Rs1E0), .Rs2E(Rs2E0), .RdE(RdE0), .stall_cnt(stall_cnt0)
  );

  assign d_pack = {RdD, Rs1D, Rs2D, alu_ctrlD, resultsrcD, memwriteD, alusrcD, regwriteD,
                   rd1D, rd2D, immextD, pcD};
  assign e_pack = {RdE, Rs1E, Rs2E, alu_ctrlE, resultsrcE, memwriteE, alusrcE, regwriteE,
                   srcA, Rd2E, immextE, pcE};

  // Scoreboard: pop on output transfer, drop everything on flush/reset, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got=%h", e_pack);
        end else begin
          exp_v = exp_q.pop_front();
          if (e_pack !== exp_v) begin
            errors++;
            $display("FAIL sb_bundle got=%h expected=%h", e_pack, exp_v);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(d_pack);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic ordy, input logic fl, input logic rs,
                        input logic mw, input logic rw, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid   = iv;
    out_ready  = ordy;
    flush      = fl;
    resultsrcD = rs;
    memwriteD  = mw;
    regwriteD  = rw;
    RdD        = rd;
    Rs1D       = rs1;
    Rs2D       = rs2;
    alusrcD    = 1'($urandom_range(0, 1));
    alu_ctrlD  = alu_op_t'(4'($urandom_range(0, 8)));
    rd1D       = $urandom;
    rd2D       = $urandom;
    immextD    = $urandom;
    pcD        = $urandom;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
    end
  endtask

  typedef struct {
    logic       iv, ordy, rs, rw;
    logic [4:0] rd, rs1, rs2;
    logic       e_ir, e_ov, e_rw;
    int         e_st;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic rs, input logic rw,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic e_ir, input logic e_ov, input logic e_rw, input int e_st);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.rs = rs; v.rw = rw;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_rw = e_rw; v.e_st = e_st;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int acc_t;
    //            iv ordy rs rw rd  rs1 rs2  ir ov rw stall
    tbl[0]  = mk(1, 1, 1, 1,  5, 0,  0,  1, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1,  6, 5,  0,  0, 1, 1, 0);
    tbl[2]  = mk(1, 1, 0, 1,  6, 5,  0,  1, 0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0,  0, 0,  0,  1, 1, 1, 1);
    tbl[4]  = mk(1, 1, 1, 1,  0, 0,  0,  1, 0, 0, 1);
    tbl[5]  = mk(1, 1, 0, 1,  7, 0,  0,  1, 1, 1, 1);
    tbl[6]  = mk(0, 1, 0, 0,  0, 0,  0,  1, 1, 1, 1);
    tbl[7]  = mk(0, 1, 0, 0,  0, 0,  0,  1, 0, 0, 1);
    tbl[8]  = mk(1, 0, 1, 1,  9, 0,  0,  1, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 1, 10, 0,  0,  1, 1, 1, 1);
    tbl[10] = mk(1, 0, 1, 1, 11, 0,  9,  0, 1, 1, 1);
    tbl[11] = mk(1, 1, 1, 1, 11, 0,  9,  0, 1, 1, 1);
    tbl[12] = mk(1, 0, 1, 1, 11, 0,  9,  1, 1, 1, 1);
    tbl[13] = mk(1, 0, 0, 1, 12, 0, 11,  0, 1, 1, 1);
    tbl[14] = mk(1, 1, 0, 1, 12, 0, 11,  0, 1, 1, 2);
    tbl[15] = mk(1, 1, 0, 1, 12, 0, 11,  0, 1, 1, 3);
    tbl[16] = mk(1, 1, 0, 1, 12, 0, 11,  1, 0, 0, 4);
    tbl[17] = mk(0, 1, 0, 0,  0, 0,  0,  1, 1, 1, 4);
    tbl[18] = mk(0, 1, 0, 0,  0, 0,  0,  1, 0, 0, 4);

    // Reset state
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_RdE", 64'(RdE), 64'd0);
    chk("rst_pcE", 64'(pcE), 64'd0);
    chk("rst_alu_ctrlE", 64'(alu_ctrlE), 64'd0);
    chk("rst_out_valid_skid0", 64'(out_valid0), 64'd0);
    tick();
    rst = 1'b0;

    // Streaming: 8 back-to-back bundles, one-cycle latency
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'(k), 5'd0, 5'd0);
      else        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      if (k <= 8) begin
        chk($sformatf("stream%0d_in_ready", k), 64'(in_ready), 64'd1);
        chk($sformatf("stream%0d_in_ready_skid0", k), 64'(in_ready0), 64'd1);
      end
      if (k > 1) begin
        chk($sformatf("stream%0d_out_valid", k), 64'(out_valid), 64'd1);
        chk($sformatf("stream%0d_RdE", k), 64'(RdE), 64'(k - 1));
        chk($sformatf("stream%0d_out_valid_skid0", k), 64'(out_valid0), 64'd1);
        chk($sformatf("stream%0d_RdE_skid0", k), 64'(RdE0), 64'(k - 1));
      end
      tick();
    end
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    idle(2);

    // Load-use table
    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].iv, tbl[i].ordy, 1'b0, tbl[i].rs, 1'b0, tbl[i].rw,
             tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
      @(negedge clk);
      chk($sformatf("lu%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("lu%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("lu%0d_regwriteE", i), 64'(regwriteE), 64'(tbl[i].e_rw));
      chk($sformatf("lu%0d_stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_st));
      tick();
    end
    idle(3);

    // Backpressure: three offered while stalled, two held, FIFO release
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 5'd0, 5'd0);
    @(negedge clk);
    chk("bp_a_in_ready", 64'(in_ready), 64'd1);
    chk("bp_a_in_ready_skid0", 64'(in_ready0), 64'd1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 5'd0, 5'd0);
    @(negedge clk);
    chk("bp_b_in_ready", 64'(in_ready), 64'd1);
    chk("bp_b_RdE", 64'(RdE), 64'd13);
    chk("bp_b_in_ready_skid0", 64'(in_ready0), 64'd0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 5'd0, 5'd0);
    @(negedge clk);
    chk("bp_c_in_ready", 64'(in_ready), 64'd0);
    chk("bp_c_out_valid", 64'(out_valid), 64'd1);
    chk("bp_c_RdE_hold", 64'(RdE), 64'd13);
    tick();
    acc_t = -1;
    for (int t = 0; t < 4 && acc_t < 0; t++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 5'd0, 5'd0);
      @(negedge clk);
      if (in_ready) acc_t = t;
      tick();
    end
    chk("bp_c_accept_cycle", 64'(acc_t), 64'd1);
    idle(3);
    chk("bp_queue_drained", 64'(exp_q.size()), 64'd0);

    // Flush with main and skid both full; a store sits in main
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 5'd0, 5'd0);
    @(negedge clk);
    chk("fl_e_in_ready", 64'(in_ready), 64'd1);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd18, 5'd0, 5'd0);
    @(negedge clk);
    chk("fl_in_ready_during_flush", 64'(in_ready), 64'd0);
    chk("fl_memwriteE_before", 64'(memwriteE), 64'd1);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_memwriteE", 64'(memwriteE), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_out_valid_skid0", 64'(out_valid0), 64'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("fl_out_valid_after", 64'(out_valid), 64'd0);
    tick();

    // Reset mid-stream with main and skid full
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd19, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd21, 5'd0, 5'd0);
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    chk("mrst_out_valid_before", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_RdE", 64'(RdE), 64'd0);
    chk("mrst_pcE", 64'(pcE), 64'd0);
    chk("mrst_alu_ctrlE", 64'(alu_ctrlE), 64'd0);
    chk("mrst_memwriteE", 64'(memwriteE), 64'd0);
    chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("mrst_in_ready_held", 64'(in_ready), 64'd0);
    chk("mrst_out_valid_skid0", 64'(out_valid0), 64'd0);
    tick();
    rst = 1'b0;
    idle(1);

    // Saturation: load held in main, dependent bundle offered for 20 cycles
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0);
    @(negedge clk);
    chk("sat_load_in_ready", 64'(in_ready), 64'd1);
    tick();
    for (int i = 1; i <= 20; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd3, 5'd0);
      @(negedge clk);
      chk($sformatf("sat%0d_in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("sat%0d_stall_cnt", i), 64'(stall_cnt), 64'((i - 1) > 15 ? 15 : (i - 1)));
      tick();
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("sat_final_stall_cnt", 64'(stall_cnt), 64'd15);
    tick();
    idle(3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
Parametrised decode-to-execute pipeline register for the rv32i core, replacing the free-running ID/EX flop bank. Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and load-use hazard detection with bubble insertion. It also keeps a saturating stall-cycle counter. Sits between the decode logic (control unit, register file, extend unit) and the execute stage.

Parameters:
DPW, 32, datapath width (rd1/rd2/immext/pc)
ADW, 5, register address width
SKID, 1, 0 = single register with combinational in_ready; 1 = main + skid entry with registered in_ready
CNTW, 16, width of stall_cnt

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decode bundle valid
in_ready  out  1  decode bundle accepted this cycle when in_valid & in_ready
flush  in  1  squash all held entries (branch/jump redirect)
resultsrcD, memwriteD, alusrcD, regwriteD  in  1 each  decode control
alu_ctrlD  in  alu_op_t  ALU operation
rd1D, rd2D, immextD, pcD  in  DPW each  operands, immediate, PC
Rs1D, Rs2D, RdD  in  ADW each  source/dest register addresses
out_valid  out  1  execute bundle valid
out_ready  in  1  execute stage consumes when out_valid & out_ready
resultsrcE, memwriteE, alusrcE, regwriteE  out  1 each  registered control
alu_ctrlE  out  alu_op_t  registered ALU op
srcA, Rd2E, immextE, pcE  out  DPW each  registered data
Rs1E, Rs2E, RdE  out  ADW each  registered addresses (for forwarding unit)
stall_cnt  out  CNTW  load-use stall cycles, saturating

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, skid empty, every E output 0, alu_ctrlE = enum value 0, stall_cnt=0. in_ready=0 while rst=1.
- Bubble safety: memwriteE and regwriteE are driven 0 whenever out_valid=0, regardless of register contents.
- Latency: accepted bundle appears on E outputs the next cycle. Throughput is 1/cycle when out_ready=1 and there is no hazard.
- SKID=0: in_ready = !rst & !flush & !hazard & (!out_valid | out_ready). Main register loads on input transfer. Otherwise out_valid clears on output transfer.
- SKID=1: in_ready = !rst & !flush & !hazard & !skid_full_q.
  - Input transfer while main is valid and not draining: bundle goes to skid.
  - Main drains while skid is full: skid moves to main in the same cycle, and a new input (if any) goes to skid.
  - Ordering is strictly FIFO. No bundle is dropped or duplicated.
- Hazard (load-use): the youngest valid held entry Y (skid if full, else main) is checked.
  - hazard = in_valid & Y.valid & Y.resultsrc & Y.regwrite & (Y.Rd != 0) & (Y.Rd == Rs1D | Y.Rd == Rs2D).
  - On hazard the input is held (in_ready=0). If main drains that cycle with the skid empty, main loads a bubble (out_valid=0).
  - One stall cycle suffices once the load has left the structure.
- Flush: priority below rst, above everything else. Next cycle out_valid=0 and skid empty. No input is accepted in the flush cycle. An output transfer coincident with flush still counts as consumed.
- stall_cnt: increments by 1 in each cycle where hazard=1. Saturates at all-ones (no wrap). Cleared only by rst.
- Simultaneous in/out transfer with main valid and skid empty: main is replaced by the new bundle, and out_valid stays 1.
- out_ready=0 indefinitely: E outputs and out_valid hold stable (AXI-style: valid does not drop without a transfer, except on flush/rst).

Decomposition:
- rv32i_pkg: add id_ex_bundle_t (packed struct of all D-side fields, widths from DPW/ADW) and reuse alu_op_t. Parametrise with localparams or a type parameter.
- Sub-module pipe_skid_buf: generic 2-entry valid/ready skid buffer over a bundle type with flush. It exposes the youngest-entry bundle/valid for the hazard check. id_ex_pipe holds only the hazard logic, the bubble/regwrite gating and the counter.

Test Plan:
- Streaming: 8 back-to-back bundles (RdD=1..8, no loads), out_ready=1 -> each appears one cycle later in order, out_valid held 1, stall_cnt=0.
- Load-use: main holds load (resultsrcE=1, regwriteE=1, RdE=5), incoming Rs1D=5 -> in_ready=0 one cycle, bubble (out_valid=0, regwriteE=0), then the bundle is accepted. stall_cnt=1. Repeat with RdE=0 -> no stall.
- Backpressure (SKID=1): out_ready=0 for 3 cycles with 3 bundles offered -> 2 accepted (main+skid), in_ready=0 on the third. On release the order is A, B, C with no loss.
- Flush: with main and skid both full, assert flush for 1 cycle -> next cycle out_valid=0, memwriteE=0, in_ready=1. A bundle offered during flush is not accepted.
- Reset mid-stream: rst asserted while out_valid=1 and the skid is full -> all outputs 0 next cycle, stall_cnt=0, in_ready=0 while rst=1.
- Saturation (CNTW=4): hold hazard for 20 cycles -> stall_cnt reaches 15 and stays 15.
